// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// state encoding, default widths and pipeline control words.
package pipeline_pkg;

  localparam int DEF_REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_FLUSH = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
  } ctrl_t;

  // NOP/bubble word: no holds, no flushes
  localparam ctrl_t CTRL_NOP   = 6'b000000;
  localparam ctrl_t CTRL_HOLD  = 6'b110101;
  localparam ctrl_t CTRL_BR    = 6'b001010;
  localparam ctrl_t CTRL_DRAIN = 6'b001000;
  localparam ctrl_t CTRL_LU    = 6'b110010;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the debug performance counters.
// Holds at all-ones; cleared only by reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage pipeline: load-use,
// taken branches resolved in EX and data-memory waits.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken_ex,
  input  logic                  dmem_busy,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic [1:0]            state_out,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      branch_flushes
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  state_t     eval;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       resume;
  logic       resume_nxt;
  logic       load_use;
  logic       br_event;
  ctrl_t      ctl;
  ctrl_t      ctl_o;

  assign load_use = ex_mem_read &
    ((id_uses_rn & (ex_rd == id_rn)) |
     (id_uses_rm & (ex_rd == id_rm)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_RUN;
      cnt    <= '0;
      resume <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      resume <= resume_nxt;
    end
  end

  always_comb begin
    ctl        = CTRL_NOP;
    state_nxt  = state;
    cnt_nxt    = cnt;
    resume_nxt = resume;
    br_event   = 1'b0;
    eval       = state;
    // the wait's exit cycle behaves as the state it interrupted
    if ((state == ST_MEM_WAIT) && !dmem_busy) begin
      eval = resume ? ST_BR_FLUSH : ST_RUN;
    end
    case (eval)
      ST_MEM_WAIT: begin
        ctl = CTRL_HOLD;
      end
      ST_BR_FLUSH: begin
        if (dmem_busy) begin
          ctl        = CTRL_HOLD;
          resume_nxt = 1'b1;
          state_nxt  = ST_MEM_WAIT;
        end else begin
          ctl        = CTRL_DRAIN;
          cnt_nxt    = cnt - 4'd1;
          resume_nxt = 1'b0;
          state_nxt  = (cnt <= 4'd1) ? ST_RUN : ST_BR_FLUSH;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        unique case (1'b1)
          dmem_busy: begin
            ctl        = CTRL_HOLD;
            resume_nxt = 1'b0;
            state_nxt  = ST_MEM_WAIT;
          end
          (!dmem_busy && branch_taken_ex): begin
            ctl       = CTRL_BR;
            br_event  = 1'b1;
            cnt_nxt   = FLUSH_LAST;
            state_nxt = (FLUSH_CYCLES > 1) ? ST_BR_FLUSH : ST_RUN;
          end
          (!dmem_busy && !branch_taken_ex && load_use): begin
            ctl = CTRL_LU;
          end
          default: begin
          end
        endcase
      end
    endcase
  end

  assign ctl_o        = reset ? CTRL_NOP : ctl;
  assign pc_stall     = ctl_o.pc_stall;
  assign if_id_stall  = ctl_o.if_id_stall;
  assign if_id_flush  = ctl_o.if_id_flush;
  assign id_ex_stall  = ctl_o.id_ex_stall;
  assign id_ex_flush  = ctl_o.id_ex_flush;
  assign ex_mem_stall = ctl_o.ex_mem_stall;
  assign state_out    = state;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctl_o.pc_stall),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (br_event & ~reset),
    .count (branch_flushes)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a second,
// narrow-counter instance for the saturation case.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  id_rn, id_rm, ex_rd;
  logic        id_uses_rn, id_uses_rm, ex_mem_read;
  logic        branch_taken_ex, dmem_busy;
  logic        pc_stall, if_id_stall, if_id_flush;
  logic        id_ex_stall, id_ex_flush, ex_mem_stall;
  logic [1:0]  state_out;
  logic [15:0] stall_cycles, branch_flushes;
  logic        s_pc, s_ifs, s_iff, s_exs, s_exf, s_ms;
  logic [1:0]  s_state;
  logic [3:0]  s_stall, s_br;
  logic [5:0]  ctl, s_ctl;
  int          checks = 0;
  int          failures = 0;

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] HOLD  = 6'b110101;
  localparam logic [5:0] BR    = 6'b001010;
  localparam logic [5:0] DRAIN = 6'b001000;
  localparam logic [5:0] LU    = 6'b110010;

  always #5 clk = ~clk;

  assign ctl = {pc_stall, if_id_stall, if_id_flush,
                id_ex_stall, id_ex_flush, ex_mem_stall};
  assign s_ctl = {s_pc, s_ifs, s_iff, s_exs, s_exf, s_ms};

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken_ex(branch_taken_ex), .dmem_busy(dmem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
    .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .state_out(state_out), .stall_cycles(stall_cycles),
    .branch_flushes(branch_flushes)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken_ex(branch_taken_ex), .dmem_busy(dmem_busy),
    .pc_stall(s_pc), .if_id_stall(s_ifs),
    .if_id_flush(s_iff), .id_ex_stall(s_exs),
    .id_ex_flush(s_exf), .ex_mem_stall(s_ms),
    .state_out(s_state), .stall_cycles(s_stall),
    .branch_flushes(s_br)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rn = 4'd0; id_rm = 4'd0; ex_rd = 4'd0;
    id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_mem_read = 1'b0;
    branch_taken_ex = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rd = 4'd3;
    id_rn = 4'd3; id_uses_rn = 1'b1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    dmem_busy = 1'b1;
    branch_taken_ex = 1'b1;
    nxt(); #1;
    chk("reset_ctl", 32'(ctl), 32'(NONE));
    nxt(); #1;
    chk("reset_state", 32'(state_out), 0);
    chk("reset_stall_cnt", 32'(stall_cycles), 0);
    chk("reset_br_cnt", 32'(branch_flushes), 0);
    reset = 1'b0;
    idle();

    // load-use through rn
    nxt(); set_lu(); #1;
    chk("lu_rn_ctl", 32'(ctl), 32'(LU));
    nxt(); idle(); #1;
    chk("lu_after_ctl", 32'(ctl), 32'(NONE));
    chk("lu_stall_cnt", 32'(stall_cycles), 1);
    chk("lu_state", 32'(state_out), 0);

    // rm match but rm unused, then used
    nxt();
    ex_mem_read = 1'b1; ex_rd = 4'd5; id_rm = 4'd5; id_rn = 4'd1;
    id_uses_rn = 1'b1; #1;
    chk("lu_rm_unused", 32'(ctl), 32'(NONE));
    id_uses_rm = 1'b1; #1;
    chk("lu_rm_used", 32'(ctl), 32'(LU));
    ex_mem_read = 1'b0; #1;
    chk("lu_not_load", 32'(ctl), 32'(NONE));

    // taken branch, FLUSH_CYCLES=2
    nxt(); idle(); branch_taken_ex = 1'b1; #1;
    chk("br_c0_ctl", 32'(ctl), 32'(BR));
    nxt(); idle(); #1;
    chk("br_c1_ctl", 32'(ctl), 32'(DRAIN));
    chk("br_c1_state", 32'(state_out), 1);
    nxt(); #1;
    chk("br_c2_ctl", 32'(ctl), 32'(NONE));
    chk("br_c2_state", 32'(state_out), 0);
    chk("br_cnt", 32'(branch_flushes), 1);

    // memory wait for 4 cycles
    nxt(); dmem_busy = 1'b1; #1;
    chk("mw_c1_ctl", 32'(ctl), 32'(HOLD));
    for (int i = 2; i <= 4; i++) begin
      nxt(); #1;
      chk("mw_ctl", 32'(ctl), 32'(HOLD));
      chk("mw_state", 32'(state_out), 2);
    end
    nxt(); dmem_busy = 1'b0; #1;
    chk("mw_exit_ctl", 32'(ctl), 32'(NONE));
    nxt(); #1;
    chk("mw_exit_state", 32'(state_out), 0);
    chk("mw_stall_cnt", 32'(stall_cycles), 5);

    // busy + branch + load-use together
    nxt(); set_lu(); branch_taken_ex = 1'b1; dmem_busy = 1'b1; #1;
    chk("sim_c0_ctl", 32'(ctl), 32'(HOLD));
    nxt(); #1;
    chk("sim_c1_ctl", 32'(ctl), 32'(HOLD));
    chk("sim_c1_state", 32'(state_out), 2);
    nxt(); dmem_busy = 1'b0; #1;
    chk("sim_exit_ctl", 32'(ctl), 32'(BR));
    nxt(); idle(); #1;
    chk("sim_drain_ctl", 32'(ctl), 32'(DRAIN));
    chk("sim_drain_state", 32'(state_out), 1);
    nxt(); #1;
    chk("sim_done_ctl", 32'(ctl), 32'(NONE));
    chk("sim_br_cnt", 32'(branch_flushes), 2);
    chk("sim_stall_cnt", 32'(stall_cycles), 7);

    // busy while BR_FLUSH holds counter=1
    nxt(); branch_taken_ex = 1'b1; #1;
    chk("bw_br_ctl", 32'(ctl), 32'(BR));
    nxt(); idle(); dmem_busy = 1'b1; #1;
    chk("bw_pause_ctl", 32'(ctl), 32'(HOLD));
    chk("bw_pause_state", 32'(state_out), 1);
    nxt(); #1;
    chk("bw_wait_ctl", 32'(ctl), 32'(HOLD));
    chk("bw_wait_state", 32'(state_out), 2);
    nxt(); dmem_busy = 1'b0; #1;
    chk("bw_resume_ctl", 32'(ctl), 32'(DRAIN));
    nxt(); #1;
    chk("bw_run_ctl", 32'(ctl), 32'(NONE));
    chk("bw_run_state", 32'(state_out), 0);
    chk("bw_br_cnt", 32'(branch_flushes), 3);
    chk("bw_stall_cnt", 32'(stall_cycles), 9);
    chk("narrow_stall_cnt", 32'(s_stall), 9);

    // reset in the middle of a wait
    nxt(); dmem_busy = 1'b1; #1;
    nxt(); #1;
    chk("rw_state_pre", 32'(state_out), 2);
    reset = 1'b1; #1;
    chk("rw_ctl_in_reset", 32'(ctl), 32'(NONE));
    nxt(); #1;
    chk("rw_state", 32'(state_out), 0);
    chk("rw_stall_cnt", 32'(stall_cycles), 0);
    chk("rw_br_cnt", 32'(branch_flushes), 0);

    // 20 stall cycles: narrow counter saturates at 15
    reset = 1'b0;
    repeat (20) nxt();
    dmem_busy = 1'b0; #1;
    chk("sat_wide_cnt", 32'(stall_cycles), 20);
    chk("sat_narrow_cnt", 32'(s_stall), 15);
    nxt(); #1;
    chk("sat_narrow_ctl", 32'(s_ctl), 32'(NONE));
    chk("sat_narrow_state", 32'(s_state), 0);
    chk("sat_narrow_br", 32'(s_br), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage ARM pipeline. It sits beside the IF/ID and ID/EX pipeline registers and generates their stall (hold) and flush (bubble) controls. It handles load-use hazards, taken branches resolved in EX, and multi-cycle data-memory waits. Two saturating performance counters are exposed for debug.

Parameters:
REG_ADDR_W, 4, width of register specifiers (R0-R15)
FLUSH_CYCLES, 2, number of cycles if_id_flush is held after a taken branch (1..15)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_rn  in  REG_ADDR_W  first source register of the instruction in ID
id_rm  in  REG_ADDR_W  second source register of the instruction in ID
id_uses_rn  in  1  ID instruction reads rn
id_uses_rm  in  1  ID instruction reads rm
ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load (mem_to_reg_select=1 and reg_write_enable=1)
branch_taken_ex  in  1  branch resolved taken in EX this cycle
dmem_busy  in  1  data memory not ready; MEM stage must hold
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  clear IF/ID register to NOP
id_ex_stall  out  1  hold ID/EX register (its hold enable)
id_ex_flush  out  1  load all-zero control signals into ID/EX (bubble)
ex_mem_stall  out  1  hold EX/MEM register
state_out  out  2  current FSM state (debug)
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1
branch_flushes  out  CNT_W  saturating count of taken-branch events

Behaviour:
- Reset: state RUN, flush counter 0, resume flag 0, both perf counters 0. All control outputs 0 while reset is high; reset overrides every input.
- load_use = ex_mem_read & ((id_uses_rn & ex_rd==id_rn) | (id_uses_rm & ex_rd==id_rm)).
- Control outputs are Mealy: a function of state and current inputs, effective in the same cycle. No added latency.
- States: RUN=0, BR_FLUSH=1, MEM_WAIT=2. Encoding 3 is illegal and returns to RUN.
- Event priority in RUN is dmem_busy > branch_taken_ex > load_use.
- RUN, dmem_busy=1:
  - Asserts pc_stall, if_id_stall, id_ex_stall, ex_mem_stall. No flushes.
  - Next state MEM_WAIT, resume flag=0.
- RUN, branch_taken_ex=1:
  - Asserts if_id_flush and id_ex_flush. No stalls.
  - If FLUSH_CYCLES>1: counter=FLUSH_CYCLES-1, next state BR_FLUSH. Otherwise stays in RUN.
  - branch_flushes increments.
- RUN, load_use=1:
  - Asserts pc_stall, if_id_stall, id_ex_flush. This is exactly one bubble.
  - Stays in RUN. The hazard clears the next cycle because the load has advanced to MEM.
- RUN, no event: all control outputs 0.
- BR_FLUSH:
  - Asserts if_id_flush only. The counter decrements each cycle.
  - Returns to RUN in the cycle after the counter reaches 1.
  - dmem_busy=1: stall set as in MEM_WAIT with no flush, counter frozen, resume flag=1, next state MEM_WAIT.
  - branch_taken_ex and load_use are ignored in BR_FLUSH because ID/EX holds only bubbles.
- MEM_WAIT:
  - While dmem_busy=1: all four stall outputs asserted, no flushes.
  - On the first cycle dmem_busy=0, that cycle is evaluated exactly as RUN (or BR_FLUSH if resume flag=1) and the state returns there.
  - A branch_taken_ex held during the wait is therefore acted on once, in that exit cycle.
- stall_cycles and branch_flushes are each CNT_W bits wide, saturate at all-ones, and are cleared only by reset.
- Stall and flush for the same register are never both asserted in the same cycle. Flush wins by construction of the above rules.

Decomposition:
- Shared package pipeline_pkg holds:
  - State encoding constants ST_RUN, ST_BR_FLUSH, ST_MEM_WAIT.
  - REG_ADDR_W default.
  - The NOP/bubble control-word value.
- One sub-module is natural: sat_counter (parameter WIDTH; inputs clk, reset, inc; output count), instantiated twice for the performance counters.
- The hazard comparator stays inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_rn=3, id_uses_rn=1 for one cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle, 0 next cycle, stall_cycles=1.
- Branch with FLUSH_CYCLES=2: branch_taken_ex pulse -> cycle0 if_id_flush=id_ex_flush=1; cycle1 if_id_flush=1 only; cycle2 all 0, state_out=0, branch_flushes=1.
- Memory wait: dmem_busy high 4 cycles -> four stall outputs high exactly 4 cycles, state_out=2 for cycles 2-4, stall_cycles=4.
- Simultaneous events: dmem_busy=1 with branch_taken_ex=1 and load_use=1 -> stalls only, no flush. On dmem_busy drop, branch flush occurs in the exit cycle and the load-use bubble is suppressed.
- dmem_busy=1 during BR_FLUSH with counter=1 -> flush paused. After dmem_busy drops, one if_id_flush cycle, then RUN.
- Reset asserted mid-MEM_WAIT -> next cycle all outputs 0, state_out=0, counters 0. Counter saturation is checked by forcing 2^CNT_W stall cycles with CNT_W=4: the counter holds at 15.
